motor_ramp_ctrl: RTL

Upstream command stage for the dual-motor PWM generator. Accepts left/right speed and direction commands over a valid/ready handshake. Slews each channel's duty toward its target at a fixed rate. On any direction reversal, decelerates to zero, dwells, then reaccelerates. Outputs registered duty/direction pairs that drive the PWM generator's duty inputs and H-bridge direction selects.

---
 rtl/motor_ramp_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
//
// Command stage in front of the dual-motor PWM generator. Left/right speed and
// direction commands arrive over a valid/ready handshake. Each channel's duty
// is slewed toward its target at STEP per ramp tick. Any direction reversal
// decelerates the channel to zero duty, dwells for DEAD_CYCLES clocks, flips
// the bridge direction and then reaccelerates. The bridge direction therefore
// only ever changes while the duty is zero.
//
// Parameters:
//   RAMP_DIV     clocks per ramp tick
//   STEP         duty change per ramp tick
//   DUTY_MAX     ceiling applied to commanded speeds
//   DEAD_CYCLES  zero-duty dwell before a direction flip, in clocks
//
// Ports:
//   clk              system clock
//   rst_n            asynchronous active-low reset
//   cmd_valid        command present
//   cmd_ready        command can be accepted
//   cmd_left_dir     left target direction, 1 = forward
//   cmd_left_speed   left target duty
//   cmd_right_dir    right target direction, 1 = forward
//   cmd_right_speed  right target duty
//   estop            emergency stop, level sensitive
//   left_duty        left duty to PWM stage
//   left_dir         left direction to H-bridge
//   right_duty       right duty to PWM stage
//   right_dir        right direction to H-bridge
//   settled          both channels idle/running at their targets
//
// Build option:
//   ESTOP_LATCH_EN   when defined, estop is held in a sticky latch that is
//                    cleared only by accepting a 0/0 command while estop is low.
// -----------------------------------------------------------------------------
module motor_ramp_ctrl #(
  parameter int RAMP_DIV    = 50000,
  parameter int STEP        = 1,
  parameter int DUTY_MAX    = 100,
  parameter int DEAD_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_left_dir,
  input  logic [7:0] cmd_left_speed,
  input  logic       cmd_right_dir,
  input  logic [7:0] cmd_right_speed,
  input  logic       estop,
  output logic [7:0] left_duty,
  output logic       left_dir,
  output logic [7:0] right_duty,
  output logic       right_dir,
  output logic       settled
);

  localparam int CW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [CW-1:0] CNT_LAST   = CW'(RAMP_DIV - 1);
  localparam logic [DW-1:0] DWELL_LOAD = DW'(DEAD_CYCLES - 1);
  localparam logic [8:0]    STEP9      = 9'(STEP);
  localparam logic [7:0]    DUTY_MAX8  = 8'(DUTY_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP,
    S_RUN,
    S_DECEL,
    S_DWELL
  } state_t;

  // ---------------------------------------------------------------------------
  // Arithmetic helpers
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] sat_speed(input logic [7:0] s);
    sat_speed = (s > DUTY_MAX8) ? DUTY_MAX8 : s;
  endfunction

  // One STEP toward tgt, never passing it. Done in 9 bits so neither direction
  // can wrap; a borrow out of the subtraction means we went below zero.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt);
    logic [8:0] up;
    logic [8:0] dn;
    up = {1'b0, cur} + STEP9;
    dn = {1'b0, cur} - STEP9;
    if (cur < tgt) begin
      step_toward = (up > {1'b0, tgt}) ? tgt : up[7:0];
    end else if (cur > tgt) begin
      step_toward = (dn[8] || (dn < {1'b0, tgt})) ? tgt : dn[7:0];
    end else begin
      step_toward = cur;
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Free-running ramp tick
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;

  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and emergency stop
  // ---------------------------------------------------------------------------
  logic accept;
  logic kill;

`ifdef ESTOP_LATCH_EN
  logic latch_q, latch_d;
  logic zero_cmd;

  assign zero_cmd = (cmd_left_speed == 8'd0) && (cmd_right_speed == 8'd0);
  // Ready has to look at the command payload here (a 0/0 command is the only
  // way out of the latch), so it is decoded directly rather than from a flop.
  assign cmd_ready = !estop && (!latch_q || zero_cmd);
  assign accept    = cmd_valid && cmd_ready;
  assign kill      = estop || latch_q;

  always_comb begin
    latch_d = latch_q;
    if (estop) begin
      latch_d = 1'b1;
    end else if (accept && zero_cmd) begin
      latch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      latch_q <= 1'b0;
    end else begin
      latch_q <= latch_d;
    end
  end
`else
  logic ready_q;

  assign cmd_ready = ready_q;
  assign accept    = cmd_valid && ready_q;
  assign kill      = estop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b1;
    end else begin
      ready_q <= !estop;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Channel targets (index 0 = left, 1 = right)
  // ---------------------------------------------------------------------------
  logic [7:0] tgt_spd_q [2];
  logic       tgt_dir_q [2];
  logic [7:0] cmd_spd   [2];
  logic       cmd_dir   [2];

  always_comb begin
    cmd_spd[0] = sat_speed(cmd_left_speed);
    cmd_spd[1] = sat_speed(cmd_right_speed);
    cmd_dir[0] = cmd_left_dir;
    cmd_dir[1] = cmd_right_dir;
  end

  // Estop wins over a coincident accept and leaves the direction targets alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        tgt_spd_q[c] <= '0;
        tgt_dir_q[c] <= 1'b1;
      end
    end else if (estop) begin
      for (int c = 0; c < 2; c++) begin
        tgt_spd_q[c] <= '0;
      end
    end else if (accept) begin
      for (int c = 0; c < 2; c++) begin
        tgt_spd_q[c] <= cmd_spd[c];
        tgt_dir_q[c] <= cmd_dir[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel ramp FSMs
  // ---------------------------------------------------------------------------
  state_t        state_q [2], state_d [2];
  logic [7:0]    duty_q  [2], duty_d  [2];
  logic          dir_q   [2], dir_d   [2];
  logic [DW-1:0] dwell_q [2], dwell_d [2];
  logic          ok      [2];

  // Targets are registered, so a tick coinciding with the accept edge still
  // steps toward the old target; the new one is seen from the next edge on.
  // Steps that land on the target/zero change state in the same edge so the
  // state always agrees with the duty that is being driven out.
  always_comb begin
    logic [7:0] nxt;
    for (int c = 0; c < 2; c++) begin
      nxt        = duty_q[c];
      state_d[c] = state_q[c];
      duty_d[c]  = duty_q[c];
      dir_d[c]   = dir_q[c];
      dwell_d[c] = dwell_q[c];
      if (kill) begin
        state_d[c] = S_IDLE;
        duty_d[c]  = '0;
      end else begin
        unique case (state_q[c])
          S_IDLE: begin
            duty_d[c] = '0;
            if (tgt_spd_q[c] != 8'd0) begin
              if (tgt_dir_q[c] != dir_q[c]) begin
                state_d[c] = S_DWELL;
                dwell_d[c] = DWELL_LOAD;
              end else begin
                nxt        = tick ? step_toward(8'd0, tgt_spd_q[c]) : 8'd0;
                duty_d[c]  = nxt;
                state_d[c] = (nxt == tgt_spd_q[c]) ? S_RUN : S_RAMP;
              end
            end
          end
          S_RAMP, S_RUN, S_DECEL: begin
            if ((state_q[c] == S_DECEL) || (tgt_dir_q[c] != dir_q[c])) begin
              nxt       = tick ? step_toward(duty_q[c], 8'd0) : duty_q[c];
              duty_d[c] = nxt;
              if (nxt == 8'd0) begin
                state_d[c] = S_DWELL;
                dwell_d[c] = DWELL_LOAD;
              end else begin
                state_d[c] = S_DECEL;
              end
            end else begin
              nxt        = tick ? step_toward(duty_q[c], tgt_spd_q[c]) : duty_q[c];
              duty_d[c]  = nxt;
              state_d[c] = (nxt == tgt_spd_q[c]) ? S_RUN : S_RAMP;
            end
          end
          S_DWELL: begin
            // Commands arriving here only move the targets; the dwell runs out
            // regardless and then picks up whatever the latest target is.
            duty_d[c] = '0;
            if (dwell_q[c] == '0) begin
              dir_d[c]   = tgt_dir_q[c];
              state_d[c] = (tgt_spd_q[c] != 8'd0) ? S_RAMP : S_IDLE;
            end else begin
              dwell_d[c] = dwell_q[c] - 1'b1;
            end
          end
          default: begin
            state_d[c] = S_IDLE;
            duty_d[c]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= S_IDLE;
        duty_q[c]  <= '0;
        dir_q[c]   <= 1'b1;
        dwell_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c] <= state_d[c];
        duty_q[c]  <= duty_d[c];
        dir_q[c]   <= dir_d[c];
        dwell_q[c] <= dwell_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Settled flag
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      ok[c] = ((state_q[c] == S_IDLE) || (state_q[c] == S_RUN)) &&
              (duty_q[c] == tgt_spd_q[c]) &&
              (dir_q[c] == tgt_dir_q[c]);
    end
  end

  logic settled_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settled_q <= 1'b1;
    end else begin
      settled_q <= ok[0] && ok[1];
    end
  end

  assign left_duty  = duty_q[0];
  assign left_dir   = dir_q[0];
  assign right_duty = duty_q[1];
  assign right_dir  = dir_q[1];
  assign settled    = settled_q;

endmodule
